// File: rtl/data_mem_if.sv
// Purpose: request/response bundle between the opcode control unit and the data memory responder.
// Latency: none, wires only; the responder answers WAIT_CYCLES+1 cycles after acceptance.
// Backpressure: the master watches mem_busy; requests are only accepted while the responder is idle.
// Ports: memory_cs / memory_r_w_en / memory_address / mem_size / mem_unsigned / mem_wdata (request),
//        mem_rdata / mem_ready / mem_busy / mem_error (response).
interface data_mem_if;
  logic        memory_cs;
  logic        memory_r_w_en;
  logic [31:0] memory_address;
  logic [1:0]  mem_size;
  logic        mem_unsigned;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        mem_busy;
  logic        mem_error;

  modport master (
    output memory_cs, memory_r_w_en, memory_address, mem_size, mem_unsigned, mem_wdata,
    input  mem_rdata, mem_ready, mem_busy, mem_error
  );

  modport slave (
    input  memory_cs, memory_r_w_en, memory_address, mem_size, mem_unsigned, mem_wdata,
    output mem_rdata, mem_ready, mem_busy, mem_error
  );
endinterface

// File: rtl/data_mem_responder.sv
// Purpose: byte/half/word data memory with wait states and sign/zero-extending loads.
// Latency: mem_ready pulses WAIT_CYCLES+1 cycles after the accepting cycle (one request in flight).
// Backpressure: memory_cs is ignored while mem_busy is high; no queueing.
// Ports: clk, rst_n (async active-low), bus (data_mem_if.slave).
// Build option: define DMEM_MISALIGN_CHECK_EN to reject misaligned half/word accesses
//   (no write, mem_rdata=0, mem_error=1); without it low address bits are ignored.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  data_mem_if.slave   bus
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t      state, state_d;
  logic [3:0]  cnt, cnt_d;
  logic        enter_resp;

  // captured request
  logic        req_we;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_uns;
  logic [31:0] req_wdata;

  // response registers
  logic [31:0] rdata_q;
  logic        ready_q;
  logic        error_q;

  logic [31:0] mem [DEPTH_WORDS];

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    enter_resp = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.memory_cs) begin
          if (WAIT_CYCLES == 0) begin
            state_d    = ST_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = 4'(WAIT_CYCLES);
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_d    = ST_RESP;
          enter_resp = 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------- request capture ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_we    <= 1'b0;
      req_addr  <= '0;
      req_size  <= '0;
      req_uns   <= 1'b0;
      req_wdata <= '0;
    end else if (state == ST_IDLE && bus.memory_cs) begin
      req_we    <= bus.memory_r_w_en;
      req_addr  <= bus.memory_address;
      req_size  <= bus.mem_size;
      req_uns   <= bus.mem_unsigned;
      req_wdata <= bus.mem_wdata;
    end
  end

  // With zero wait states the access happens on the accepting edge itself,
  // so the live bus fields are used while still in IDLE.
  logic        op_we, op_uns;
  logic [31:0] op_addr, op_wdata;
  logic [1:0]  op_size;

  assign op_we    = (state == ST_IDLE) ? bus.memory_r_w_en  : req_we;
  assign op_addr  = (state == ST_IDLE) ? bus.memory_address : req_addr;
  assign op_size  = (state == ST_IDLE) ? bus.mem_size       : req_size;
  assign op_uns   = (state == ST_IDLE) ? bus.mem_unsigned   : req_uns;
  assign op_wdata = (state == ST_IDLE) ? bus.mem_wdata      : req_wdata;

  logic [AW-1:0] idx;
  assign idx = op_addr[AW+1:2];

  // upper address bits only wrap the address space
  logic unused_addr_bits;
  assign unused_addr_bits = ^op_addr[31:AW+2];

  logic misalign;
`ifdef DMEM_MISALIGN_CHECK_EN
  assign misalign = ((op_size == 2'b01) && op_addr[0]) ||
                    (op_size[1] && (op_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // ---------------- lane steering ----------------
  logic [3:0]  be;
  logic [31:0] wdat;

  always_comb begin
    be   = 4'b1111;
    wdat = op_wdata;
    case (op_size)
      2'b00: begin
        be   = 4'b0001 << op_addr[1:0];
        wdat = {4{op_wdata[7:0]}};
      end
      2'b01: begin
        be   = op_addr[1] ? 4'b1100 : 4'b0011;
        wdat = {2{op_wdata[15:0]}};
      end
      default: begin
        be   = 4'b1111;
        wdat = op_wdata;
      end
    endcase
  end

  logic [31:0] rd_word, rd_shift, load_val;
  logic [15:0] rd_half;

  assign rd_word  = mem[idx];
  assign rd_shift = rd_word >> {op_addr[1:0], 3'b000};
  assign rd_half  = op_addr[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    load_val = rd_word;
    case (op_size)
      2'b00:   load_val = {{24{~op_uns & rd_shift[7]}}, rd_shift[7:0]};
      2'b01:   load_val = {{16{~op_uns & rd_half[15]}}, rd_half};
      default: load_val = rd_word;
    endcase
  end

  // ---------------- storage (never reset) ----------------
  // rst_n gate keeps a request racing an asserted reset from committing.
  always_ff @(posedge clk) begin
    if (enter_resp && rst_n && op_we && !misalign) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdat[8*b +: 8];
      end
    end
  end

  // ---------------- response ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q <= 1'b0;
      error_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      ready_q <= enter_resp;
      error_q <= enter_resp & misalign;
      if (enter_resp) begin
        if (misalign)    rdata_q <= '0;
        else if (!op_we) rdata_q <= load_val;
      end
    end
  end

  assign bus.mem_rdata = rdata_q;
  assign bus.mem_ready = ready_q;
  assign bus.mem_error = error_q;
  assign bus.mem_busy  = (state != ST_IDLE);

endmodule

// File: tb/tb_data_mem_responder.sv
// Purpose: randomized scoreboard bench for data_mem_responder against a byte-array model.
// Latency: expects mem_ready exactly 3 cycles after the accepting cycle (WAIT_CYCLES=2).
// Backpressure: driver tracks when the responder may accept; requests offered while busy are dropped.
module tb_data_mem_responder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  data_mem_if bus();

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
    int          acc;
    bit          has_lit;
    logic [31:0] lit;
  } req_t;

  req_t        q[$];
  logic [7:0]  mb [0:1023];
  logic [31:0] last_rdata = '0;
  int          cyc = 0;
  int          next_free = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  bit          in_reset = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'b00) ? 1 : ((s == 2'b01) ? 2 : 4);
  endfunction

  function automatic bit misaligned(input logic [1:0] s, input logic [31:0] a);
`ifdef DMEM_MISALIGN_CHECK_EN
    int n = nbytes(s);
    return (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  // Reference: memory is 1024 little-endian bytes; accesses are aligned down to their size.
  task automatic apply(input req_t r, output logic [31:0] rd, output bit err);
    int n = nbytes(r.size);
    int base = int'(r.addr % 32'd1024);
    logic [31:0] v;
    base = base - (base % n);
    err = misaligned(r.size, r.addr);
    if (err) begin
      last_rdata = '0;
    end else if (r.we) begin
      for (int i = 0; i < n; i++) mb[base + i] = r.wdata[8*i +: 8];
    end else begin
      v = '0;
      for (int i = 0; i < n; i++) v = v | (32'(mb[base + i]) << (8 * i));
      if (!r.uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
      last_rdata = v;
    end
    rd = last_rdata;
  endtask

  // ---------------- monitor ----------------
  req_t        m_r;
  logic [31:0] m_rd;
  bit          m_err, exp_rdy, exp_busy;

  always @(posedge clk) begin
    #1;
    if (in_reset) begin
      chk("rst_ready", bus.mem_ready, 0);
      chk("rst_busy",  bus.mem_busy,  0);
      chk("rst_rdata", bus.mem_rdata, 0);
      chk("rst_error", bus.mem_error, 0);
    end else begin
      exp_rdy  = (q.size() > 0) && (q[0].acc + 3 == cyc);
      exp_busy = (q.size() > 0) && (cyc > q[0].acc);
      chk("ready", bus.mem_ready, exp_rdy);
      chk("busy",  bus.mem_busy,  exp_busy);
      if (exp_rdy) begin
        m_r = q.pop_front();
        apply(m_r, m_rd, m_err);
        chk("error", bus.mem_error, m_err);
        chk("rdata", bus.mem_rdata, m_rd);
        if (m_r.has_lit) chk("rdata_lit", bus.mem_rdata, m_r.lit);
      end
    end
  end

  // ---------------- driver ----------------
  function automatic req_t mk(input logic we, input logic [31:0] a, input logic [1:0] s,
                              input logic uns, input logic [31:0] wd,
                              input bit hl, input logic [31:0] lit);
    req_t r;
    r.we = we; r.addr = a; r.size = s; r.uns = uns; r.wdata = wd;
    r.acc = 0; r.has_lit = hl; r.lit = lit;
    return r;
  endfunction

  task automatic drive(input bit cs, input req_t r, output bit acc);
    req_t rr = r;
    @(negedge clk);
    bus.memory_cs      = cs;
    bus.memory_r_w_en  = r.we;
    bus.memory_address = r.addr;
    bus.mem_size       = r.size;
    bus.mem_unsigned   = r.uns;
    bus.mem_wdata      = r.wdata;
    acc = 1'b0;
    if (cs && cyc >= next_free) begin
      acc = 1'b1;
      rr.acc = cyc;
      q.push_back(rr);
      next_free = cyc + 4;
    end
  endtask

  task automatic issue(input req_t r);
    bit a = 1'b0;
    while (!a) drive(1'b1, r, a);
  endtask

  task automatic idle(input int n);
    bit a;
    repeat (n) drive(1'b0, mk(0, 0, 0, 0, 0, 0, 0), a);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n = 1'b0;
    in_reset = 1'b1;
    bus.memory_cs = 1'b0;
    q.delete();
    last_rdata = '0;
    #1;
    chk("async_rst_ready", bus.mem_ready, 0);
    chk("async_rst_busy",  bus.mem_busy,  0);
    chk("async_rst_rdata", bus.mem_rdata, 0);
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
    in_reset = 1'b0;
    next_free = cyc;
  endtask

  initial begin
    bit a;
    rst_n = 1'b0;
    bus.memory_cs = 1'b0; bus.memory_r_w_en = 1'b0; bus.memory_address = '0;
    bus.mem_size = '0; bus.mem_unsigned = 1'b0; bus.mem_wdata = '0;
    #1;
    chk("init_ready", bus.mem_ready, 0);
    chk("init_busy",  bus.mem_busy,  0);
    chk("init_rdata", bus.mem_rdata, 0);
    chk("init_error", bus.mem_error, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    in_reset = 1'b0;
    next_free = cyc;

    // fill every word so later loads have defined contents
    for (int i = 0; i < 256; i++) issue(mk(1, 32'(4 * i), 2'b10, 0, $urandom, 0, 0));

    // word store / load
    issue(mk(1, 32'h10, 2'b10, 0, 32'hDEADBEEF, 0, 0));
    issue(mk(0, 32'h10, 2'b10, 0, 0, 1, 32'hDEADBEEF));
    // byte lane + extension
    issue(mk(1, 32'h13, 2'b00, 0, 32'h0000_0080, 0, 0));
    issue(mk(0, 32'h13, 2'b00, 0, 0, 1, 32'hFFFF_FF80));
    issue(mk(0, 32'h13, 2'b00, 1, 0, 1, 32'h0000_0080));
    issue(mk(0, 32'h10, 2'b10, 0, 0, 1, 32'h80AD_BEEF));
    // halfword upper lane, signed and unsigned
    issue(mk(1, 32'h12, 2'b01, 0, 32'h0000_9234, 0, 0));
    issue(mk(0, 32'h12, 2'b01, 0, 0, 1, 32'hFFFF_9234));
    issue(mk(0, 32'h12, 2'b01, 1, 0, 1, 32'h0000_9234));

    // memory_cs held for 10 cycles: only every 4th cycle is accepted
    for (int i = 0; i < 10; i++) drive(1'b1, mk(0, 32'($urandom_range(0, 1023)), 2'b10, 0, 0, 0, 0), a);
    idle(4);

    // address wrap
    issue(mk(1, 32'h400, 2'b10, 0, 32'h12345678, 0, 0));
    issue(mk(0, 32'h0, 2'b10, 0, 0, 1, 32'h12345678));

    // reset during WAIT aborts the pending store
    issue(mk(1, 32'h20, 2'b10, 0, 32'h0000AAAA, 0, 0));
    issue(mk(1, 32'h20, 2'b10, 0, 32'h00005555, 0, 0));
    do_reset(2);
    issue(mk(0, 32'h20, 2'b10, 0, 0, 1, 32'h0000AAAA));

    // misaligned word store
    issue(mk(1, 32'h21, 2'b10, 0, 32'hCAFEF00D, 0, 0));
`ifdef DMEM_MISALIGN_CHECK_EN
    issue(mk(0, 32'h20, 2'b10, 0, 0, 1, 32'h0000AAAA));
`else
    issue(mk(0, 32'h20, 2'b10, 0, 0, 1, 32'hCAFEF00D));
`endif
    idle(4);

    // randomized mix
    for (int i = 0; i < 300; i++) begin
      issue(mk(1'($urandom_range(0, 1)), 32'($urandom_range(0, 4095)),
               2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom, 0, 0));
      if ($urandom_range(0, 3) == 0) idle(1 + $urandom_range(0, 4));
    end

    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    chk("drain_empty", q.size(), 0);
    bus.memory_cs = 1'b0;
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
